// File: rtl/huffman_merge_ctrl.sv
`timescale 1ns/1ps
// Huffman merge sequencer: loads six symbol counts, then performs five
// min-pair merge rounds and emits one {sum, flag} record per round.
module huffman_merge_ctrl #(
  parameter logic [2:0] SET  = 3'd2,
  parameter logic [2:0] SORT = 3'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cnt1,
  input  logic [7:0]  cnt2,
  input  logic [7:0]  cnt3,
  input  logic [7:0]  cnt4,
  input  logic [7:0]  cnt5,
  input  logic [7:0]  cnt6,
  output logic [14:0] cnt_o1,
  output logic [14:0] cnt_o2,
  output logic [14:0] cnt_o3,
  output logic [14:0] cnt_o4,
  output logic [14:0] cnt_o5,
  output logic [14:0] cnt_o6,
  output logic [2:0]  state,
  output logic [2:0]  addr,
  output logic [7:0]  sum,
  output logic [6:0]  flag,
  output logic        merge_valid,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FIND = 3'd1;
  localparam logic [2:0] FIN  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_in [6];
  logic [14:0] cnt_o_q [6];
  logic [7:0]  w_q [6];
  logic [5:0]  m_q [6];
  logic [5:0]  act_q;
  logic [2:0]  round_q;
  logic [2:0]  a_q, b_q;
  logic [2:0]  a_idx, b_idx, lo_idx, hi_idx;
  logic        a_ok, b_ok;
  logic [8:0]  sum9;
  logic [7:0]  sum_q;
  logic [6:0]  flag_q;
  logic [2:0]  addr_q;
  logic        ovf_q;
  logic        busy_d, done_d, mv_d;
  logic        busy_q, done_q, mv_q;
  logic        accept;

  assign cnt_in[0] = cnt1;
  assign cnt_in[1] = cnt2;
  assign cnt_in[2] = cnt3;
  assign cnt_in[3] = cnt4;
  assign cnt_in[4] = cnt5;
  assign cnt_in[5] = cnt6;

  // start is a level request honoured only in IDLE; busy covers the whole run,
  // so start seen while busy (or held through FIN) has no effect.
  assign accept = (state_q == IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SET;
      SET:     state_d = FIND;
      FIND:    state_d = SORT;
      SORT:    state_d = (round_q == 3'd4) ? FIN : FIND;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
    mv_d   = (state_d == SORT);
  end

  // Lightest active slot first, then the lightest of the rest; strict '<'
  // keeps the lower index on ties.
  always_comb begin
    a_idx = 3'd0;
    b_idx = 3'd0;
    a_ok  = 1'b0;
    b_ok  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (act_q[i] && (!a_ok || w_q[i] < w_q[a_idx])) begin
        a_idx = 3'(i);
        a_ok  = 1'b1;
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (act_q[i] && (3'(i) != a_idx) && (!b_ok || w_q[i] < w_q[b_idx])) begin
        b_idx = 3'(i);
        b_ok  = 1'b1;
      end
    end
  end

  assign sum9   = {1'b0, w_q[a_idx]} + {1'b0, w_q[b_idx]};
  assign lo_idx = (a_q < b_q) ? a_q : b_q;
  assign hi_idx = (a_q < b_q) ? b_q : a_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        w_q[i]     <= '0;
        m_q[i]     <= '0;
        cnt_o_q[i] <= '0;
      end
      act_q   <= '0;
      round_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      flag_q  <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      mv_q   <= mv_d;
      if (accept) begin
        for (int i = 0; i < 6; i++) begin
          w_q[i]     <= cnt_in[i];
          m_q[i]     <= 6'b100000 >> i;
          cnt_o_q[i] <= {cnt_in[i], 1'b0, 6'b100000 >> i};
        end
        act_q   <= 6'h3F;
        round_q <= '0;
        sum_q   <= '0;
        flag_q  <= '0;
        addr_q  <= '0;
        ovf_q   <= 1'b0;
      end
      if (state_q == FIND) begin
        sum_q  <= sum9[8] ? 8'hFF : sum9[7:0];
        flag_q <= {1'b1, m_q[a_idx] | m_q[b_idx]};
        addr_q <= round_q;
        a_q    <= a_idx;
        b_q    <= b_idx;
        if (sum9[8]) ovf_q <= 1'b1;
      end
      // Merged node lives on in the lower slot; sum_q already holds the saturated weight.
      if (state_q == SORT) begin
        w_q[lo_idx]   <= sum_q;
        m_q[lo_idx]   <= flag_q[5:0];
        act_q[hi_idx] <= 1'b0;
        round_q       <= round_q + 3'd1;
      end
    end
  end

  assign state       = state_q;
  assign addr        = addr_q;
  assign sum         = sum_q;
  assign flag        = flag_q;
  assign merge_valid = mv_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ovf         = ovf_q;
  assign cnt_o1      = cnt_o_q[0];
  assign cnt_o2      = cnt_o_q[1];
  assign cnt_o3      = cnt_o_q[2];
  assign cnt_o4      = cnt_o_q[3];
  assign cnt_o5      = cnt_o_q[4];
  assign cnt_o6      = cnt_o_q[5];

endmodule

// File: tb/tb_huffman_merge_ctrl.sv
`timescale 1ns/1ps
// Bench for huffman_merge_ctrl: directed and random runs compared every cycle
// against a run-phase model whose merge records come from a plain array search.
module tb_huffman_merge_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cnt_tb [6];
  logic [14:0] cnt_o1, cnt_o2, cnt_o3, cnt_o4, cnt_o5, cnt_o6;
  logic [2:0]  state, addr;
  logic [7:0]  sum;
  logic [6:0]  flag;
  logic        merge_valid, busy, done, ovf;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int          phase = 0;
  logic [7:0]  rec_sum  [5];
  logic [6:0]  rec_flag [5];
  logic        rec_sat  [5];
  logic [7:0]  sum_m = '0;
  logic [6:0]  flag_m = '0;
  logic [2:0]  addr_m = '0;
  logic        ovf_m = 1'b0;
  logic [14:0] cnt_m [6];

  huffman_merge_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .cnt1(cnt_tb[0]), .cnt2(cnt_tb[1]), .cnt3(cnt_tb[2]),
    .cnt4(cnt_tb[3]), .cnt5(cnt_tb[4]), .cnt6(cnt_tb[5]),
    .cnt_o1(cnt_o1), .cnt_o2(cnt_o2), .cnt_o3(cnt_o3),
    .cnt_o4(cnt_o4), .cnt_o5(cnt_o5), .cnt_o6(cnt_o6),
    .state(state), .addr(addr), .sum(sum), .flag(flag),
    .merge_valid(merge_valid), .busy(busy), .done(done), .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Five rounds of "merge the two lightest live nodes" over plain arrays.
  task automatic compute_model();
    int   w [6];
    logic [5:0] m [6];
    bit   act [6];
    int   a, b, s, lo, hi, live;
    for (int i = 0; i < 6; i++) begin
      w[i] = int'(cnt_tb[i]);
      m[i] = 6'b100000 >> i;
      act[i] = 1'b1;
    end
    for (int r = 0; r < 5; r++) begin
      a = -1;
      b = -1;
      for (int i = 0; i < 6; i++)
        if (act[i] && (a < 0 || w[i] < w[a])) a = i;
      for (int i = 0; i < 6; i++)
        if (act[i] && i != a && (b < 0 || w[i] < w[b])) b = i;
      s = w[a] + w[b];
      rec_sat[r] = (s > 255);
      if (s > 255) s = 255;
      rec_sum[r]  = 8'(s);
      rec_flag[r] = {1'b1, m[a] | m[b]};
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      w[lo] = s;
      m[lo] = m[a] | m[b];
      act[hi] = 1'b0;
    end
    live = 0;
    for (int i = 0; i < 6; i++) if (act[i]) live++;
    chk("model_live_nodes", 32'(live), 32'd1);
    chk("model_final_mask", {25'd0, rec_flag[4]}, 32'h7F);
  endtask

  // Run-phase model: phase 1 = SETC, 2..11 FIND/MERGE pairs, 12 = FIN, 0 = idle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= 0;
      sum_m  <= '0;
      flag_m <= '0;
      addr_m <= '0;
      ovf_m  <= 1'b0;
      for (int i = 0; i < 6; i++) cnt_m[i] <= '0;
    end else if (phase == 0) begin
      if (start) begin
        phase  <= 1;
        sum_m  <= '0;
        flag_m <= '0;
        addr_m <= '0;
        ovf_m  <= 1'b0;
        for (int i = 0; i < 6; i++) cnt_m[i] <= {cnt_tb[i], 1'b0, 6'b100000 >> i};
      end
    end else begin
      phase <= (phase == 12) ? 0 : phase + 1;
      if (phase >= 2 && phase <= 10 && phase % 2 == 0) begin
        sum_m  <= rec_sum[(phase - 2) / 2];
        flag_m <= rec_flag[(phase - 2) / 2];
        addr_m <= 3'((phase - 2) / 2);
        if (rec_sat[(phase - 2) / 2]) ovf_m <= 1'b1;
      end
    end
  end

  function automatic logic [2:0] exp_state(input int p);
    if (p == 0)       return 3'd0;
    else if (p == 1)  return 3'd2;
    else if (p == 12) return 3'd4;
    else if (p % 2 == 0) return 3'd1;
    else return 3'd3;
  endfunction

  // scoreboard: every cycle, on the falling edge
  always @(negedge clk) begin
    chk("state", {29'd0, state}, {29'd0, exp_state(phase)});
    chk("busy", {31'd0, busy}, {31'd0, phase != 0});
    chk("done", {31'd0, done}, {31'd0, phase == 12});
    chk("merge_valid", {31'd0, merge_valid}, {31'd0, (phase >= 3 && phase <= 11 && phase % 2 == 1)});
    chk("addr", {29'd0, addr}, {29'd0, addr_m});
    chk("sum", {24'd0, sum}, {24'd0, sum_m});
    chk("flag", {25'd0, flag}, {25'd0, flag_m});
    chk("ovf", {31'd0, ovf}, {31'd0, ovf_m});
    chk("cnt_o1", {17'd0, cnt_o1}, {17'd0, cnt_m[0]});
    chk("cnt_o2", {17'd0, cnt_o2}, {17'd0, cnt_m[1]});
    chk("cnt_o3", {17'd0, cnt_o3}, {17'd0, cnt_m[2]});
    chk("cnt_o4", {17'd0, cnt_o4}, {17'd0, cnt_m[3]});
    chk("cnt_o5", {17'd0, cnt_o5}, {17'd0, cnt_m[4]});
    chk("cnt_o6", {17'd0, cnt_o6}, {17'd0, cnt_m[5]});
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2,
                            input int c3, input int c4, input int c5);
    cnt_tb[0] = 8'(c0); cnt_tb[1] = 8'(c1); cnt_tb[2] = 8'(c2);
    cnt_tb[3] = 8'(c3); cnt_tb[4] = 8'(c4); cnt_tb[5] = 8'(c5);
    compute_model();
  endtask

  // Leaves the bench in cycle 1 (SETC) of the new run.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic random_run();
    int mode, hold;
    mode = $urandom_range(0, 3);
    for (int i = 0; i < 6; i++) begin
      case (mode)
        0: cnt_tb[i] = 8'($urandom_range(0, 15));
        1: cnt_tb[i] = 8'($urandom_range(0, 255));
        2: cnt_tb[i] = (i == 0) ? 8'($urandom_range(0, 255)) : cnt_tb[0];
        default: cnt_tb[i] = 8'($urandom_range(100, 255));
      endcase
    end
    compute_model();
    hold = $urandom_range(0, 1);
    if (hold != 0) begin
      start = 1'b1;
      wait_steps(14);
      start = 1'b0;
      wait_steps(13);
    end else begin
      kick();
      wait_steps(12 + $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) cnt_tb[i] = '0;
    wait_steps(3);
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    wait_steps(2);

    // basic run
    set_counts(5, 3, 8, 1, 2, 9);
    chk("pin_sum0", {24'd0, rec_sum[0]}, 32'd3);
    chk("pin_flag0", {25'd0, rec_flag[0]}, 32'h46);
    chk("pin_sum1", {24'd0, rec_sum[1]}, 32'd6);
    chk("pin_flag1", {25'd0, rec_flag[1]}, 32'h56);
    chk("pin_sum2", {24'd0, rec_sum[2]}, 32'd11);
    chk("pin_flag2", {25'd0, rec_flag[2]}, 32'h76);
    chk("pin_sum3", {24'd0, rec_sum[3]}, 32'd17);
    chk("pin_flag3", {25'd0, rec_flag[3]}, 32'h49);
    chk("pin_sum4", {24'd0, rec_sum[4]}, 32'd28);
    chk("pin_flag4", {25'd0, rec_flag[4]}, 32'h7F);
    kick();
    chk("set_state", {29'd0, state}, 32'd2);
    chk("set_cnt_o1", {17'd0, cnt_o1}, 32'h2A0);
    chk("set_cnt_o6", {17'd0, cnt_o6}, 32'h481);
    chk("set_merge_valid", {31'd0, merge_valid}, 32'd0);
    wait_steps(11);
    chk("basic_done_c12", {31'd0, done}, 32'd1);
    chk("basic_ovf", {31'd0, ovf}, 32'd0);
    wait_steps(2);

    // ties: slots 0,1 then 2,3
    set_counts(4, 4, 4, 4, 4, 4);
    chk("pin_tie_sum0", {24'd0, rec_sum[0]}, 32'd8);
    chk("pin_tie_flag0", {25'd0, rec_flag[0]}, 32'h70);
    chk("pin_tie_flag1", {25'd0, rec_flag[1]}, 32'h4C);
    kick();
    wait_steps(13);

    // saturation, then a small run clears ovf
    set_counts(200, 200, 200, 200, 200, 200);
    chk("pin_sat_sum0", {24'd0, rec_sum[0]}, 32'd255);
    kick();
    wait_steps(2);
    chk("sat_first_ovf", {31'd0, ovf}, 32'd1);
    wait_steps(11);
    chk("sat_ovf_sticky", {31'd0, ovf}, 32'd1);
    set_counts(1, 2, 3, 4, 5, 6);
    kick();
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    wait_steps(13);

    // reset in cycle 6, then a full basic run
    set_counts(5, 3, 8, 1, 2, 9);
    kick();
    wait_steps(5);
    reset = 1'b1;
    #1;
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cnt_o1", {17'd0, cnt_o1}, 32'd0);
    step();
    reset = 1'b0;
    step();
    kick();
    wait_steps(13);

    // start in cycles 4 and 12 ignored; start in cycle 13 gives SETC in 14
    kick();
    wait_steps(3);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_steps(7);
    start = 1'b1;
    step();
    chk("c13_state_idle", {29'd0, state}, 32'd0);
    step();
    start = 1'b0;
    chk("retrig_state", {29'd0, state}, 32'd2);
    wait_steps(13);

    for (int k = 0; k < 24; k++) random_run();

    wait_steps(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
